// File: rtl/bit_serial_adder.sv
// Bit-serial WIDTH-bit adder: one full-adder stage with a registered carry, LSB first.
// Define SERIAL_ADD_SUB_EN to add the sub port (A - B via inverted addend and carry-in of 1).
`timescale 1ns/1ps

module bit_serial_adder #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic             Cin,
`ifdef SERIAL_ADD_SUB_EN
   input  logic             sub,
`endif
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] Sum,
   output logic             Carry
);

   localparam int CW = $clog2(WIDTH);
   localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] a_sr_q, a_sr_d;
   logic [WIDTH-1:0] b_sr_q, b_sr_d;
   logic [WIDTH-1:0] s_sr_q, s_sr_d;
   logic             c_q, c_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH-1:0] sum_q, sum_d;
   logic             carry_q, carry_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;

   logic [WIDTH-1:0] b_load;
   logic             c_load;
   logic             s_bit;
   logic             c_next;

   // Subtraction is A + ~B + 1, so Carry reads as "no borrow".
`ifdef SERIAL_ADD_SUB_EN
   assign b_load = sub ? ~B : B;
   assign c_load = sub ? 1'b1 : Cin;
`else
   assign b_load = B;
   assign c_load = Cin;
`endif

   assign s_bit  = a_sr_q[0] ^ b_sr_q[0] ^ c_q;
   assign c_next = (a_sr_q[0] & b_sr_q[0]) | (a_sr_q[0] & c_q) | (b_sr_q[0] & c_q);

   always_comb begin
      // NOTE: every _d starts from its held value, so no branch can infer a latch.
      state_d = state_q;
      a_sr_d  = a_sr_q;
      b_sr_d  = b_sr_q;
      s_sr_d  = s_sr_q;
      c_d     = c_q;
      cnt_d   = cnt_q;
      sum_d   = sum_q;
      carry_d = carry_q;

      case (state_q)
         IDLE, DONE: begin
            state_d = IDLE;
            if (start) begin
               state_d = SHIFT;
               a_sr_d  = A;
               b_sr_d  = b_load;
               c_d     = c_load;
               cnt_d   = CNT_LAST;
            end
         end
         SHIFT: begin
            a_sr_d = a_sr_q >> 1;
            b_sr_d = b_sr_q >> 1;
            s_sr_d = {s_bit, s_sr_q[WIDTH-1:1]};
            c_d    = c_next;
            if (cnt_q == '0) begin
               state_d = DONE;
               sum_d   = {s_bit, s_sr_q[WIDTH-1:1]};
               carry_d = c_next;
            end else begin
               cnt_d = cnt_q - CW'(1);
            end
         end
         default: state_d = IDLE;
      endcase

      // Moore outputs are decoded from the next state and registered alongside it.
      busy_d = (state_d == SHIFT);
      done_d = (state_d == DONE);
   end

   // NOTE: sequential state uses non-blocking assignments only, so all flops update together.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         a_sr_q  <= '0;
         b_sr_q  <= '0;
         s_sr_q  <= '0;
         c_q     <= 1'b0;
         cnt_q   <= '0;
         sum_q   <= '0;
         carry_q <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         a_sr_q  <= a_sr_d;
         b_sr_q  <= b_sr_d;
         s_sr_q  <= s_sr_d;
         c_q     <= c_d;
         cnt_q   <= cnt_d;
         sum_q   <= sum_d;
         carry_q <= carry_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   assign busy  = busy_q;
   assign done  = done_q;
   assign Sum   = sum_q;
   assign Carry = carry_q;

endmodule
